// File: rtl/painter_pkg.sv
// Shared types and default grid geometry for the pixel painter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package painter_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int GRID_W_DEF = 16;
  localparam int GRID_H_DEF = 12;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability debouncer, rising-edge pulse.
// Latency: 2 sync cycles + DEB_CYC stable cycles before the one-cycle o_evt pulse.
// Backpressure: none; o_evt is a single-cycle pulse the consumer may drop.
module btn_debounce #(
  parameter int DEB_CYC = 750000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_evt
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_db;
  logic          r_db_q;

  // Two-flop synchronizer for the raw asynchronous button.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], i_btn};
  end

  // Accept a new level only once it has differed from the debounced level
  // for DEB_CYC consecutive cycles; any bounce back restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (r_sync[1] == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEB_CYC - 1)) begin
      r_db  <= r_sync[1];
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Delayed debounced level for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_db_q <= 1'b0;
    else          r_db_q <= r_db;
  end

  assign o_evt = r_db & ~r_db_q;

endmodule

// File: rtl/pixel_painter.sv
// Cursor-driven frame-buffer painter: buttons move a cursor and paint cells.
// Latency: write strobe one cycle after a paint event; cursor moves one cycle after a move event.
// Backpressure: none; events arriving while clearing or writing are dropped. Optional PIXEL_PAINTER_AUTOCLEAR_EN clears the buffer after reset.
module pixel_painter
  import painter_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 3,
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int DEB_CYC = 750000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bntr,
  input  logic          bntl,
  input  logic          paint,
  input  logic [DW-1:0] color,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          busy,
  output logic [3:0]    cur_x,
  output logic [3:0]    cur_y
);

  localparam int NCELL = GRID_W * GRID_H;
  localparam logic [3:0] XMAX = 4'(GRID_W - 1);
  localparam logic [3:0] YMAX = 4'(GRID_H - 1);

  generate
    if (NCELL > (1 << AW)) begin : g_size_chk
      $error("pixel_painter: GRID_W*GRID_H exceeds 2**AW");
    end
  endgenerate

  logic          w_evt_r;
  logic          w_evt_l;
  logic          w_evt_p;
  logic          w_move_r;
  logic          w_move_l;
  logic [AW-1:0] w_cur_addr;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cur_x;
  logic [3:0]    r_cur_y;
  logic [3:0]    w_cur_x_nxt;
  logic [3:0]    w_cur_y_nxt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_nxt;
  logic [DW-1:0] r_data;
  logic [DW-1:0] w_data_nxt;
  logic          r_wr;
  logic          w_wr_nxt;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_r (.i_clk(clk), .i_rst_n(rst), .i_btn(bntr),  .o_evt(w_evt_r));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_l (.i_clk(clk), .i_rst_n(rst), .i_btn(bntl),  .o_evt(w_evt_l));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_p (.i_clk(clk), .i_rst_n(rst), .i_btn(paint), .o_evt(w_evt_p));

  // Opposing moves in the same cycle cancel.
  assign w_move_r   = w_evt_r & ~w_evt_l;
  assign w_move_l   = w_evt_l & ~w_evt_r;
  assign w_cur_addr = AW'(r_cur_x) + AW'(AW'(r_cur_y) * AW'(GRID_W));

`ifdef PIXEL_PAINTER_AUTOCLEAR_EN
  localparam state_t RST_STATE = CLEAR;
  localparam int     CCW       = AW + 1;

  logic [CCW-1:0] r_clr_cnt;
  logic [CCW-1:0] w_clr_cnt_nxt;

  // Clear sweep counter; runs one past the last cell so the final write is still flagged busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_clr_cnt <= '0;
    else      r_clr_cnt <= w_clr_cnt_nxt;
  end

  assign busy = (r_state == CLEAR);
`else
  localparam state_t RST_STATE = IDLE;

  assign busy = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RST_STATE;
    else      r_state <= w_state_nxt;
  end

  // Next-state, next cursor and next write-port values.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_x_nxt = r_cur_x;
    w_cur_y_nxt = r_cur_y;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_wr_nxt    = 1'b0;
`ifdef PIXEL_PAINTER_AUTOCLEAR_EN
    w_clr_cnt_nxt = r_clr_cnt;
`endif
    case (r_state)
`ifdef PIXEL_PAINTER_AUTOCLEAR_EN
      CLEAR: begin
        if (r_clr_cnt == CCW'(NCELL)) begin
          w_state_nxt = IDLE;
        end else begin
          w_wr_nxt      = 1'b1;
          w_addr_nxt    = r_clr_cnt[AW-1:0];
          w_data_nxt    = '0;
          w_clr_cnt_nxt = r_clr_cnt + CCW'(1);
        end
      end
`endif
      IDLE: begin
        // Paint uses the pre-move cursor; a concurrent move still applies.
        if (w_evt_p) begin
          w_state_nxt = WRITE;
          w_wr_nxt    = 1'b1;
          w_addr_nxt  = w_cur_addr;
          w_data_nxt  = color;
        end
        if (w_move_r) begin
          if (r_cur_x == XMAX) begin
            w_cur_x_nxt = 4'd0;
            w_cur_y_nxt = (r_cur_y == YMAX) ? 4'd0 : r_cur_y + 4'd1;
          end else begin
            w_cur_x_nxt = r_cur_x + 4'd1;
          end
        end else if (w_move_l) begin
          if (r_cur_x == 4'd0) begin
            w_cur_x_nxt = XMAX;
            w_cur_y_nxt = (r_cur_y == 4'd0) ? YMAX : r_cur_y - 4'd1;
          end else begin
            w_cur_x_nxt = r_cur_x - 4'd1;
          end
        end
      end
      WRITE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Cursor and registered write-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_x <= 4'd0;
      r_cur_y <= 4'd0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
    end else begin
      r_cur_x <= w_cur_x_nxt;
      r_cur_y <= w_cur_y_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_wr    <= w_wr_nxt;
    end
  end

  assign addr_in  = r_addr;
  assign data_in  = r_data;
  assign regwrite = r_wr;
  assign cur_x    = r_cur_x;
  assign cur_y    = r_cur_y;

endmodule

// File: doc/pixel_painter.md
PIXEL_PAINTER -- requirements
Module: pixel_painter

Interface
REQ-001 SHALL have parameter AW, default 8, meaning frame-buffer address width.
REQ-002 SHALL have parameter DW, default 3, meaning pixel width (RGB 111).
REQ-003 SHALL have parameter GRID_W, default 16, meaning cells per row.
REQ-004 SHALL have parameter GRID_H, default 12, meaning rows.
REQ-005 SHALL have parameter DEB_CYC, default 750000, meaning clocks an input must be stable to be accepted.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk  in  1  sole clock (75 MHz pixel clock); rst  in  1  async active-low reset.
REQ-007 SHALL have bntr  in  1  raw move-right button, active-high, asynchronous to clk.
REQ-008 SHALL have bntl  in  1  raw move-left button, active-high, asynchronous.
REQ-009 SHALL have paint  in  1  raw paint button, active-high, asynchronous.
REQ-010 SHALL have color  in  DW  pixel value to write, sampled when a write is issued.
REQ-011 SHALL have addr_in  out  AW  write address to the dual-port buffer.
REQ-012 SHALL have data_in  out  DW  write data to the dual-port buffer.
REQ-013 SHALL have regwrite  out  1  one-cycle write strobe.
REQ-014 SHALL have busy  out  1  high while clearing; button events are ignored.
REQ-015 SHALL have cur_x  out  4  and cur_y  out  4: cursor column and row.

Function
REQ-016 Each button SHALL pass a 2-FF synchronizer, then a debouncer whose output changes only after the synchronized level has held for DEB_CYC consecutive cycles.
REQ-017 An event SHALL be the 0->1 edge of a debounced level, one cycle wide.
REQ-018 FSM states SHALL be CLEAR, IDLE and WRITE.
REQ-019 In CLEAR: one write per cycle of data 0 to addresses 0..GRID_W*GRID_H-1 ascending, then IDLE; busy=1 throughout.
REQ-020 In IDLE, a paint event in cycle n SHALL give WRITE in n+1: regwrite=1, addr_in=cur_x+cur_y*GRID_W, data_in=color as sampled in cycle n; then IDLE in n+2.
REQ-021 In IDLE, a bntr event SHALL increment cur_x in the next cycle; at GRID_W-1, cur_x wraps to 0 and cur_y increments; at the last cell, both wrap to 0.
REQ-022 In IDLE, a bntl event SHALL decrement the cursor as the mirror of REQ-021; at cell 0 it wraps to (GRID_W-1, GRID_H-1).
REQ-023 Simultaneous bntr and bntl events SHALL leave the cursor unchanged.
REQ-024 A paint event simultaneous with a move event SHALL write at the pre-move cursor and apply the move in the same cycle.
REQ-025 Events arriving in CLEAR or WRITE SHALL be dropped, not queued.
REQ-026 regwrite SHALL be 0 outside CLEAR and WRITE; addr_in and data_in SHALL hold their last values when idle.
REQ-027 The address product SHALL be computed at AW bits; GRID_W*GRID_H SHALL be at most 2**AW (elaboration check).

Reset
REQ-028 While rst=0: cur_x=0, cur_y=0, addr_in=0, data_in=0, regwrite=0, synchronizers and debouncers at 0, debounce counters at 0.
REQ-029 Reset asserted mid-CLEAR or mid-WRITE SHALL abort immediately; after release, the FSM SHALL restart per REQ-031.

Configuration
REQ-030 Macro PIXEL_PAINTER_AUTOCLEAR_EN SHALL select the feature.
REQ-031 When it is defined: after reset the FSM enters CLEAR, and busy=1 in reset. When it is undefined: the FSM enters IDLE, busy is tied to 0, and the CLEAR logic is absent.

Structure
REQ-032 Package painter_pkg SHALL hold the state enum (CLEAR/IDLE/WRITE) and the default grid constants 16/12.
REQ-033 Sub-module btn_debounce (synchronizer, counter and edge pulse) SHALL be instantiated three times.

Verification (bench uses DEB_CYC=4)
REQ-034 Autoclear reset: release rst -> regwrite=1 for 192 consecutive cycles, addr 0..191, data 0; then busy=0.
REQ-035 Cursor (7,3), color=3'b100, paint pulse held 6 cycles -> exactly one write: addr 55, data 3'b100.
REQ-036 Cursor (15,11) plus bntr -> cursor (0,0); then bntl -> cursor (15,11).
REQ-037 bntr glitch of 2 cycles -> no cursor change; both bntr and bntl pressed together -> no change.
REQ-038 Paint pressed during CLEAR -> no extra write; rst pulsed at addr 100 of CLEAR -> outputs 0, and CLEAR restarts at addr 0.
REQ-039 Build without PIXEL_PAINTER_AUTOCLEAR_EN -> busy=0 and no writes after reset; a paint at (0,0) -> addr 0 written.
